// File: rtl/ydm_pkg.sv
// rtl/ydm_pkg.sv - shared encodings for the ydm load/store unit
package ydm_pkg;

  // funct3 size/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // base byte-enable patterns before shifting into the addressed lane
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } acc_size_e;

  // Unlisted funct3 values (011, 110, 111) fall through to word
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/ydm_lane.sv
// rtl/ydm_lane.sv - byte/half/word lane steering and load extension (YDM_MISALIGN_TRAP_EN enables misalign detection)
module ydm_lane
  import ydm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        a,
  input  logic [XLEN-1:0]   rd2,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldata,
  output logic              misalign
);

  acc_size_e       size;
  logic [1:0]      a_eff;
  logic            zext;
  logic [XLEN-1:0] lane;

  // Size decode and the alignment actually used for strobes and extraction;
  // halves drop a[0] and words drop a[1:0] so memory is always hit naturally aligned.
  always_comb begin
    size  = f3_size(funct3);
    zext  = funct3[2];
    a_eff = 2'b00;
    case (size)
      SZ_B:    a_eff = a;
      SZ_H:    a_eff = {a[1], 1'b0};
      default: a_eff = 2'b00;
    endcase
  end

  // Store steering: strobe shifted into the lane, data replicated across all lanes
  always_comb begin
    wstrb = STRB_NONE;
    wdata = '0;
    case (size)
      SZ_B: begin
        wstrb = STRB_B << a_eff;
        wdata = {4{rd2[7:0]}};
      end
      SZ_H: begin
        wstrb = STRB_H << a_eff;
        wdata = {2{rd2[15:0]}};
      end
      default: begin
        wstrb = STRB_W;
        wdata = rd2;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign- or zero-extend
  always_comb begin
    lane  = rdata >> {a_eff, 3'b000};
    ldata = lane;
    case (size)
      SZ_B:    ldata = {{(XLEN-8){lane[7] & ~zext}}, lane[7:0]};
      SZ_H:    ldata = {{(XLEN-16){lane[15] & ~zext}}, lane[15:0]};
      default: ldata = lane;
    endcase
  end

`ifdef YDM_MISALIGN_TRAP_EN
  // Odd half or non-word-aligned word is reported instead of silently aligned
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = a[0];
      SZ_W:    misalign = (a != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ydm_lsu.sv
// rtl/ydm_lsu.sv - memory-access stage with req/gnt/rvalid data-memory handshake (optional YDM_MISALIGN_TRAP_EN)
module ydm_lsu
  import ydm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_z,
  input  logic [XLEN-1:0]   ex_rd2,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              dm_req,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN/8-1:0] dm_wstrb,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              misalign
);

  lsu_state_e        state;
  logic              ld_q;
  logic [2:0]        f3_q;
  logic [1:0]        a_q;
  logic [RD_W-1:0]   rd_q;

  logic              idle;
  logic              is_mem;
  logic [2:0]        lane_f3;
  logic [1:0]        lane_a;
  logic [XLEN/8-1:0] lane_wstrb;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_ldata;
  logic              lane_mis;

  assign idle     = (state == ST_IDLE);
  assign ex_ready = idle;
  assign is_mem   = ex_mem_read | ex_mem_write;

  // The lane helper sees the incoming instruction while idle (store steering,
  // misalign check) and the captured one afterwards (load extraction).
  assign lane_f3 = idle ? ex_funct3 : f3_q;
  assign lane_a  = idle ? ex_z[1:0] : a_q;

  ydm_lane #(.XLEN(XLEN)) u_lane (
    .funct3   (lane_f3),
    .a        (lane_a),
    .rd2      (ex_rd2),
    .rdata    (dm_rdata),
    .wstrb    (lane_wstrb),
    .wdata    (lane_wdata),
    .ldata    (lane_ldata),
    .misalign (lane_mis)
  );

  // Single FSM owning the memory request and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_wstrb <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      misalign <= 1'b0;
      ld_q     <= 1'b0;
      f3_q     <= 3'b000;
      a_q      <= 2'b00;
      rd_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_data  <= ex_z;
              wb_rd    <= ex_rd;
              state    <= ST_RESP;
            end else if (lane_mis) begin
              // faulting access: report the address, never touch memory
              wb_valid <= 1'b1;
              misalign <= 1'b1;
              wb_data  <= ex_z;
              wb_rd    <= '0;
              state    <= ST_RESP;
            end else begin
              // read wins when both read and write are flagged
              dm_req   <= 1'b1;
              dm_we    <= ~ex_mem_read;
              dm_addr  <= {ex_z[XLEN-1:2], 2'b00};
              dm_wstrb <= ex_mem_read ? '0 : lane_wstrb;
              dm_wdata <= ex_mem_read ? '0 : lane_wdata;
              ld_q     <= ex_mem_read;
              f3_q     <= ex_funct3;
              a_q      <= ex_z[1:0];
              rd_q     <= ex_rd;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dm_gnt) begin
            dm_req <= 1'b0;
            if (ld_q) begin
              state <= ST_WAIT;
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= '0;
              wb_rd    <= '0;
              state    <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (dm_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= lane_ldata;
            wb_rd    <= rd_q;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          wb_valid <= 1'b0;
          wb_data  <= '0;
          wb_rd    <= '0;
          misalign <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ydm_lsu.sv
// tb/tb_ydm_lsu.sv - randomized self-checking bench for ydm_lsu (honours YDM_MISALIGN_TRAP_EN)
module tb_ydm_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_z = '0;
  logic [31:0] ex_rd2 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [4:0]  ex_rd = '0;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt = 1'b0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ydm_lsu #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_z(ex_z), .ex_rd2(ex_rd2),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] z);
`ifdef YDM_MISALIGN_TRAP_EN
    return (int'(z[1:0]) % nbytes(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // byte offset actually used: rounded down to a multiple of the access size
  function automatic int eff_off(input logic [2:0] f3, input logic [31:0] z);
    int a = int'(z[1:0]);
    return a - (a % nbytes(f3));
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] z);
    int n = nbytes(f3);
    int s = ((1 << n) - 1) << eff_off(f3, z);
    return s[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rd2);
    int n = nbytes(f3);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rd2[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] z,
                                           input logic [31:0] rdata);
    int n = nbytes(f3);
    longint unsigned v, mask;
    v    = {32'd0, rdata} >> (8 * eff_off(f3, z));
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 64'd1) != 0) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int guard = 0;
    while (ex_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ex_ready_before_issue", {31'd0, ex_ready}, 32'd1);
  endtask

  task automatic run_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                        input logic [31:0] z, input logic [31:0] rd2, input logic [4:0] rd,
                        input int gdel, input int rdel, input logic [31:0] rdata);
    bit mem  = rd_en | wr_en;
    bit trap = mem && ref_trap(f3, z);
    logic [31:0] exp_addr  = {z[31:2], 2'b00};
    logic [3:0]  exp_strb  = rd_en ? 4'b0000 : ref_strb(f3, z);
    logic [31:0] exp_wdata = rd_en ? 32'd0 : ref_wdata(f3, rd2);
    wait_ready();
    ex_valid = 1'b1; ex_z = z; ex_rd2 = rd2; ex_mem_read = rd_en; ex_mem_write = wr_en;
    ex_funct3 = f3; ex_rd = rd;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_z = $urandom; ex_rd2 = $urandom; ex_funct3 = 3'($urandom); ex_rd = 5'($urandom);
    if (!mem || trap) begin
      @(negedge clk);
      check("alu_no_req", {31'd0, dm_req}, 32'd0);
      check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("alu_wb_data", wb_data, z);
      check("alu_wb_rd", {27'd0, wb_rd}, trap ? 32'd0 : {27'd0, rd});
      check("alu_misalign", {31'd0, misalign}, {31'd0, trap});
    end else begin
      for (int i = 0; i <= gdel; i++) begin
        @(negedge clk);
        check("req_held", {31'd0, dm_req}, 32'd1);
        check("req_we", {31'd0, dm_we}, {31'd0, !rd_en});
        check("req_addr", dm_addr, exp_addr);
        check("req_strb", {28'd0, dm_wstrb}, {28'd0, exp_strb});
        check("req_wdata", dm_wdata, exp_wdata);
        check("req_stall", {31'd0, ex_ready}, 32'd0);
        check("req_no_wb", {31'd0, wb_valid}, 32'd0);
        dm_gnt    = (i == gdel);
        dm_rvalid = (i < gdel) ? 1'($urandom) : 1'b0;
        dm_rdata  = $urandom;
      end
      @(posedge clk);
      #1;
      dm_gnt = 1'b0; dm_rvalid = 1'b0;
      if (rd_en) begin
        for (int j = 0; j <= rdel; j++) begin
          @(negedge clk);
          check("wait_req_low", {31'd0, dm_req}, 32'd0);
          check("wait_no_wb", {31'd0, wb_valid}, 32'd0);
          dm_rvalid = (j == rdel);
          dm_rdata  = (j == rdel) ? rdata : $urandom;
        end
        @(posedge clk);
        #1;
        dm_rvalid = 1'b0;
        @(negedge clk);
        check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ld_wb_data", wb_data, ref_load(f3, z, rdata));
        check("ld_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      end else begin
        @(negedge clk);
        check("st_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("st_wb_data", wb_data, 32'd0);
        check("st_wb_rd", {27'd0, wb_rd}, 32'd0);
      end
      check("mem_misalign", {31'd0, misalign}, 32'd0);
    end
    @(negedge clk);
    check("wb_pulse_end", {31'd0, wb_valid}, 32'd0);
    check("wb_data_idle", wb_data, 32'd0);
    check("wb_rd_idle", {27'd0, wb_rd}, 32'd0);
    check("mis_idle", {31'd0, misalign}, 32'd0);
    check("ready_after", {31'd0, ex_ready}, 32'd1);
  endtask

  // reset while a word load is outstanding (in REQ or in WAIT); late handshakes must be ignored
  task automatic reset_mid(input bit in_wait);
    wait_ready();
    ex_valid = 1'b1; ex_z = 32'h40; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
    ex_rd = 5'd9;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    check("rst_pre_req", {31'd0, dm_req}, 32'd1);
    if (in_wait) begin
      dm_gnt = 1'b1;
      @(posedge clk);
      #1;
      dm_gnt = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", {31'd0, dm_req}, 32'd0);
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    dm_rvalid = 1'b1; dm_gnt = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dm_rvalid = 1'b0; dm_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_wb", {31'd0, wb_valid}, 32'd0);
      check("rst_no_req", {31'd0, dm_req}, 32'd0);
      check("rst_ready_after", {31'd0, ex_ready}, 32'd1);
    end
  endtask

  initial begin
    #1;
    check("reset_ready", {31'd0, ex_ready}, 32'd1);
    check("reset_req", {31'd0, dm_req}, 32'd0);
    check("reset_addr", dm_addr, 32'd0);
    check("reset_strb", {28'd0, dm_wstrb}, 32'd0);
    check("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    run_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd7, 0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd3, 3, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 5'd4, 0, 1, 32'h00800000);
    run_op(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 5'd5, 0, 1, 32'h00800000);
    run_op(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 5'd6, 0, 0, 32'hBEEF0000);
    run_op(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd8, 0, 0, 32'hDEADBEEF);
    run_op(1'b1, 1'b1, 3'b001, 32'h12, 32'h5555, 5'd10, 1, 0, 32'h8001_7FFF);
    run_op(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd11, 0, 0, 32'h0BAD_F00D);
    run_op(1'b0, 1'b1, 3'b001, 32'h301, 32'h1234_5678, 5'd12, 0, 0, 32'h0);
    reset_mid(1'b1);
    reset_mid(1'b0);

    // randomized mix
    for (int t = 0; t < 200; t++) begin
      int unsigned kind = $urandom_range(0, 3);
      logic [2:0]  f3   = 3'($urandom);
      if (kind == 2 && f3 > 3'b010) f3 = 3'($urandom_range(0, 2));
      run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, f3, $urandom, $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
